// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types, default constants and timing helper for the
//               staged reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;

    // Edge (counted from the first non-reset edge) at which seq_done rises.
    function automatic int seq_done_edge(input int hold, input int gap, input int n);
        return hold + (n - 1) * gap + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Loadable down-counter; expire pulses once when a loaded count
//               has run down to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;
    logic             r_active;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_count  <= load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            // Going idle on the zero cycle is what makes expire a single pulse.
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign busy   = r_active;
    assign expire = r_active && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Asserts all stage resets, holds them, then releases the stages
//               one by one; restartable by an edge-qualified software request.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_rst_req,
    output logic                  sw_rst_ack,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic [1:0]            stage_idx,
    output logic                  seq_done
);

    localparam logic [1:0]       c_st_assert  = ST_ASSERT;
    localparam logic [1:0]       c_st_release = ST_RELEASE;
    localparam logic [1:0]       c_st_done    = ST_DONE;
    localparam logic [1:0]       c_last_idx   = 2'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] c_hold_load  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load   = CNT_W'(GAP_CYCLES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 4 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
        HOLD_CYCLES >= (1 << CNT_W) || GAP_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("reset_sequencer: illegal parameter combination");
    end

    logic [1:0]            r_state;
    logic [1:0]            r_next;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_done;
    logic                  r_ack;
    logic                  r_armed;

    logic                  w_accept;
    logic                  w_load;
    logic [CNT_W-1:0]      w_load_val;
    logic                  w_busy;
    logic                  w_expire;

    always_comb begin
        w_accept   = (r_state == c_st_done) && sw_rst_req && r_armed;
        w_load     = 1'b0;
        w_load_val = c_gap_load;
        case (r_state)
            c_st_assert: begin
                if (w_expire) begin
                    w_load = (r_next != c_last_idx);
                end else if (!w_busy) begin
                    // First edge of a sequence: the timer is idle, start the hold.
                    w_load     = 1'b1;
                    w_load_val = c_hold_load;
                end
            end
            c_st_release: w_load = w_expire && (r_next != c_last_idx);
            default:      w_load = 1'b0;
        endcase
    end

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (reset),
        .clr      (w_accept),
        .load     (w_load),
        .load_val (w_load_val),
        .busy     (w_busy),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_assert;
            r_next    <= 2'd0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (!sw_rst_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                c_st_assert, c_st_release: begin
                    if (w_expire) begin
                        // Shifting keeps the thermometer shape: low stages go first.
                        r_rst_out <= r_rst_out << 1;
                        if (r_next == c_last_idx) begin
                            r_state <= c_st_done;
                        end else begin
                            r_next  <= r_next + 2'd1;
                            r_state <= c_st_release;
                        end
                    end
                end
                c_st_done: begin
                    if (w_accept) begin
                        r_ack     <= 1'b1;
                        r_rst_out <= '1;
                        r_done    <= 1'b0;
                        r_armed   <= 1'b0;
                        r_next    <= 2'd0;
                        r_state   <= c_st_assert;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= c_st_assert;
            endcase
        end
    end

    assign rst_out    = r_rst_out;
    assign stage_idx  = r_next;
    assign seq_done   = r_done;
    assign sw_rst_ack = r_ack;

endmodule
`default_nettype wire
